// File: rtl/mem_exec_unit_pkg.sv
// Shared types for the memory execution stage: micro-op layout, memory access
// kinds and the stage's FSM state encoding.
package mem_exec_unit_pkg;

  localparam int XLEN               = 32;
  localparam int PRF_INT_INDEX_SIZE = 6;
  localparam int IMM_WIDTH          = 12;

  typedef enum logic {
    MEM_LOAD,
    MEM_STORE
  } mem_type_t;

  typedef enum logic [1:0] {
    MEM_B,
    MEM_H,
    MEM_W
  } mem_size_t;

  typedef struct packed {
    logic                          valid;
    mem_type_t                     mem_type;
    mem_size_t                     mem_size;
    logic                          mem_unsigned;
    logic [IMM_WIDTH-1:0]          imm;
    logic [PRF_INT_INDEX_SIZE-1:0] rd_prf_int_index;
    logic                          rd_valid;
  } micro_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WB
  } exec_state_t;

  // The issue queue keys store ordering off this rather than decoding mem_type itself.
  function automatic logic is_store(input micro_op_t op);
    return op.valid && (op.mem_type == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_exec_unit_align.sv
// Byte-lane steering for the data-cache port: store strobes/lane replication,
// load lane extraction with sign/zero extension, and alignment checking.
module mem_align_unit
  import mem_exec_unit_pkg::*;
(
  input  mem_size_t       mem_size_i,
  input  logic            mem_unsigned_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] load_word_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] laneShifted;
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;

  assign laneShifted = load_word_i >> {addr_lo_i, 3'b000};
  assign loadByte    = laneShifted[7:0];
  assign loadHalf    = laneShifted[15:0];

  // Store side: strobes and replicated data, plus natural-alignment check.
  always_comb begin
    wstrb_o      = 4'b0000;
    wdata_o      = '0;
    misaligned_o = 1'b0;
    case (mem_size_i)
      MEM_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_H: begin
        wstrb_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      MEM_W: begin
        wstrb_o      = 4'b1111;
        wdata_o      = store_data_i;
        misaligned_o = |addr_lo_i;
      end
      default: begin
        wstrb_o      = 4'b0000;
        wdata_o      = '0;
        misaligned_o = 1'b0;
      end
    endcase
  end

  // Load side: a single right shift brings the addressed lane down to bit 0.
  always_comb begin
    load_data_o = '0;
    case (mem_size_i)
      MEM_B: load_data_o = mem_unsigned_i ? {{(XLEN-8){1'b0}}, loadByte}
                                          : {{(XLEN-8){loadByte[7]}}, loadByte};
      MEM_H: load_data_o = mem_unsigned_i ? {{(XLEN-16){1'b0}}, loadHalf}
                                          : {{(XLEN-16){loadHalf[15]}}, loadHalf};
      MEM_W: load_data_o = load_word_i;
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_exec_unit.sv
// Single-issue load/store execute stage: address generation, one data-cache
// transaction per uop, then a one-cycle writeback and tag broadcast.
module mem_exec_unit
  import mem_exec_unit_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uop_valid,
  input  micro_op_t                     uop,
  input  logic [XLEN-1:0]               rs1_data,
  input  logic [XLEN-1:0]               rs2_data,
  output logic                          ex_busy,
  output logic                          dc_req_valid,
  input  logic                          dc_req_ready,
  output logic [XLEN-1:0]               dc_req_addr,
  output logic                          dc_req_we,
  output logic [XLEN-1:0]               dc_req_wdata,
  output logic [3:0]                    dc_req_wstrb,
  input  logic                          dc_resp_valid,
  input  logic [XLEN-1:0]               dc_resp_rdata,
  output logic                          wb_valid,
  output logic [PRF_INT_INDEX_SIZE-1:0] wb_prf_int_index,
  output logic [XLEN-1:0]               wb_data,
  output logic                          wb_exception,
  output logic                          ctb_valid,
  output logic [PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index
);

  exec_state_t state_q, state_d;

  mem_type_t                     memType_q;
  mem_size_t                     memSize_q;
  logic                          memUnsigned_q;
  logic [PRF_INT_INDEX_SIZE-1:0] rdIndex_q;
  logic                          rdValid_q;
  logic [XLEN-1:0]               addr_q;
  logic [XLEN-1:0]               wdata_q;
  logic [3:0]                    wstrb_q;
  logic                          exception_q;
  logic [XLEN-1:0]               rdata_q;

  logic            accept;
  logic [XLEN-1:0] effAddr;
  mem_size_t       alignSize;
  logic            alignUnsigned;
  logic [1:0]      alignAddrLo;
  logic [3:0]      alignWstrb;
  logic [XLEN-1:0] alignWdata;
  logic [XLEN-1:0] alignLoadData;
  logic            alignMisaligned;

  assign accept  = (state_q == ST_IDLE) && uop_valid && uop.valid;
  assign effAddr = rs1_data + {{(XLEN-IMM_WIDTH){uop.imm[IMM_WIDTH-1]}}, uop.imm};

  // One aligner serves both ends: the incoming uop while idle, the latched uop afterwards.
  always_comb begin
    alignSize     = memSize_q;
    alignUnsigned = memUnsigned_q;
    alignAddrLo   = addr_q[1:0];
    if (state_q == ST_IDLE) begin
      alignSize     = uop.mem_size;
      alignUnsigned = uop.mem_unsigned;
      alignAddrLo   = effAddr[1:0];
    end
  end

  mem_align_unit alignUnit (
    .mem_size_i     (alignSize),
    .mem_unsigned_i (alignUnsigned),
    .addr_lo_i      (alignAddrLo),
    .store_data_i   (rs2_data),
    .load_word_i    (rdata_q),
    .wstrb_o        (alignWstrb),
    .wdata_o        (alignWdata),
    .load_data_o    (alignLoadData),
    .misaligned_o   (alignMisaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = alignMisaligned ? ST_WB : ST_REQ;
      ST_REQ:  if (dc_req_ready) state_d = (memType_q == MEM_STORE) ? ST_WB : ST_WAIT;
      ST_WAIT: if (dc_resp_valid) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at accept; response data only while actually waiting for it.
  always_ff @(posedge clock) begin
    if (reset) begin
      memType_q     <= MEM_LOAD;
      memSize_q     <= MEM_B;
      memUnsigned_q <= 1'b0;
      rdIndex_q     <= '0;
      rdValid_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      exception_q   <= 1'b0;
      rdata_q       <= '0;
    end else begin
      if (accept) begin
        memType_q     <= uop.mem_type;
        memSize_q     <= uop.mem_size;
        memUnsigned_q <= uop.mem_unsigned;
        rdIndex_q     <= uop.rd_prf_int_index;
        rdValid_q     <= uop.rd_valid;
        addr_q        <= effAddr;
        wdata_q       <= alignWdata;
        wstrb_q       <= alignWstrb;
        exception_q   <= alignMisaligned;
      end
      if ((state_q == ST_WAIT) && dc_resp_valid) rdata_q <= dc_resp_rdata;
    end
  end

  always_comb begin
    ex_busy           = (state_q != ST_IDLE);
    dc_req_valid      = 1'b0;
    dc_req_addr       = '0;
    dc_req_we         = 1'b0;
    dc_req_wdata      = '0;
    dc_req_wstrb      = 4'b0000;
    wb_valid          = 1'b0;
    wb_prf_int_index  = '0;
    wb_data           = '0;
    wb_exception      = 1'b0;
    ctb_valid         = 1'b0;
    ctb_prf_int_index = '0;
    case (state_q)
      ST_REQ: begin
        dc_req_valid = 1'b1;
        dc_req_addr  = {addr_q[XLEN-1:2], 2'b00};
        dc_req_we    = (memType_q == MEM_STORE);
        dc_req_wdata = wdata_q;
        dc_req_wstrb = wstrb_q;
      end
      ST_WB: begin
        wb_valid     = 1'b1;
        wb_exception = exception_q;
        if ((memType_q == MEM_LOAD) && !exception_q) begin
          wb_data           = alignLoadData;
          wb_prf_int_index  = rdIndex_q;
          ctb_valid         = rdValid_q && (rdIndex_q != '0);
          ctb_prf_int_index = rdIndex_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed bench for mem_exec_unit: cache latency, lane steering, misalignment,
// reset recovery and busy-time uop rejection.
module tb_mem_exec_unit;
  import mem_exec_unit_pkg::*;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          uop_valid;
  micro_op_t                     uop;
  logic [XLEN-1:0]               rs1_data;
  logic [XLEN-1:0]               rs2_data;
  logic                          ex_busy;
  logic                          dc_req_valid;
  logic                          dc_req_ready;
  logic [XLEN-1:0]               dc_req_addr;
  logic                          dc_req_we;
  logic [XLEN-1:0]               dc_req_wdata;
  logic [3:0]                    dc_req_wstrb;
  logic                          dc_resp_valid;
  logic [XLEN-1:0]               dc_resp_rdata;
  logic                          wb_valid;
  logic [PRF_INT_INDEX_SIZE-1:0] wb_prf_int_index;
  logic [XLEN-1:0]               wb_data;
  logic                          wb_exception;
  logic                          ctb_valid;
  logic [PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index;

  int checks = 0;
  int errors = 0;

  mem_exec_unit dut (
    .clock             (clock),
    .reset             (reset),
    .uop_valid         (uop_valid),
    .uop               (uop),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .ex_busy           (ex_busy),
    .dc_req_valid      (dc_req_valid),
    .dc_req_ready      (dc_req_ready),
    .dc_req_addr       (dc_req_addr),
    .dc_req_we         (dc_req_we),
    .dc_req_wdata      (dc_req_wdata),
    .dc_req_wstrb      (dc_req_wstrb),
    .dc_resp_valid     (dc_resp_valid),
    .dc_resp_rdata     (dc_resp_rdata),
    .wb_valid          (wb_valid),
    .wb_prf_int_index  (wb_prf_int_index),
    .wb_data           (wb_data),
    .wb_exception      (wb_exception),
    .ctb_valid         (ctb_valid),
    .ctb_prf_int_index (ctb_prf_int_index)
  );

  always #5 clock = ~clock;

  // Every check lands 1 time unit after a rising edge, well clear of it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input mem_type_t t, input mem_size_t s, input logic uns,
                               input logic [11:0] imm, input logic [5:0] rd, input logic rdv,
                               input logic [31:0] a, input logic [31:0] d);
    uop.valid            = 1'b1;
    uop.mem_type         = t;
    uop.mem_size         = s;
    uop.mem_unsigned     = uns;
    uop.imm              = imm;
    uop.rd_prf_int_index = rd;
    uop.rd_valid         = rdv;
    rs1_data             = a;
    rs2_data             = d;
    uop_valid            = 1'b1;
    step();
    uop_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset         = 1'b1;
    uop_valid     = 1'b0;
    uop           = '0;
    rs1_data      = '0;
    rs2_data      = '0;
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b0;
    dc_resp_rdata = '0;
    step();
    step();
    checkOutput("rst_busy", ex_busy, 0);
    checkOutput("rst_req_valid", dc_req_valid, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_ctb_valid", ctb_valid, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    reset = 1'b0;
    step();

    // LW rd=5 from 0x1000+4, zero-wait cache.
    dc_req_ready = 1'b1;
    applyStimulus(MEM_LOAD, MEM_W, 1'b0, 12'd4, 6'd5, 1'b1, 32'h0000_1000, 32'h0);
    checkOutput("lw_req_valid", dc_req_valid, 1);
    checkOutput("lw_req_addr", dc_req_addr, 32'h0000_1004);
    checkOutput("lw_req_we", dc_req_we, 0);
    checkOutput("lw_busy", ex_busy, 1);
    step();
    checkOutput("lw_wait_no_req", dc_req_valid, 0);
    checkOutput("lw_wait_no_wb", wb_valid, 0);
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'hDEAD_BEEF;
    step();
    dc_resp_valid = 1'b0;
    checkOutput("lw_wb_valid", wb_valid, 1);
    checkOutput("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    checkOutput("lw_wb_exc", wb_exception, 0);
    checkOutput("lw_wb_idx", wb_prf_int_index, 5);
    checkOutput("lw_ctb_valid", ctb_valid, 1);
    checkOutput("lw_ctb_idx", ctb_prf_int_index, 5);
    step();
    checkOutput("lw_done_wb", wb_valid, 0);
    checkOutput("lw_done_busy", ex_busy, 0);

    // LB at 0x1004 + (-1) = 0x1003, lane 3 holds 0x80.
    applyStimulus(MEM_LOAD, MEM_B, 1'b0, 12'hFFF, 6'd7, 1'b1, 32'h0000_1004, 32'h0);
    checkOutput("lb_req_addr", dc_req_addr, 32'h0000_1000);
    step();
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'h80FF_0000;
    step();
    dc_resp_valid = 1'b0;
    checkOutput("lb_wb_data", wb_data, 32'hFFFF_FF80);
    checkOutput("lb_ctb_idx", ctb_prf_int_index, 7);
    step();

    // LBU same address.
    applyStimulus(MEM_LOAD, MEM_B, 1'b1, 12'd3, 6'd8, 1'b1, 32'h0000_1000, 32'h0);
    step();
    dc_resp_valid = 1'b1;
    step();
    dc_resp_valid = 1'b0;
    checkOutput("lbu_wb_data", wb_data, 32'h0000_0080);
    step();

    // LH at 0x1002: upper half 0x80FF, sign-extended.
    applyStimulus(MEM_LOAD, MEM_H, 1'b0, 12'd2, 6'd9, 1'b1, 32'h0000_1000, 32'h0);
    step();
    dc_resp_valid = 1'b1;
    step();
    dc_resp_valid = 1'b0;
    checkOutput("lh_wb_data", wb_data, 32'hFFFF_80FF);
    step();

    // SH at 0x2002 with the cache stalling three cycles.
    dc_req_ready = 1'b0;
    applyStimulus(MEM_STORE, MEM_H, 1'b0, 12'd2, 6'd0, 1'b0, 32'h0000_2000, 32'h1234_ABCD);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sh_stall_valid", dc_req_valid, 1);
      checkOutput("sh_stall_addr", dc_req_addr, 32'h0000_2000);
      checkOutput("sh_stall_we", dc_req_we, 1);
      checkOutput("sh_stall_wstrb", dc_req_wstrb, 4'b1100);
      checkOutput("sh_stall_wdata", dc_req_wdata, 32'hABCD_ABCD);
      checkOutput("sh_stall_busy", ex_busy, 1);
      checkOutput("sh_stall_no_wb", wb_valid, 0);
      if (i < 2) step();
    end
    dc_req_ready = 1'b1;
    step();
    checkOutput("sh_wb_valid", wb_valid, 1);
    checkOutput("sh_ctb_valid", ctb_valid, 0);
    checkOutput("sh_wb_data", wb_data, 0);
    checkOutput("sh_wb_busy", ex_busy, 1);
    step();
    checkOutput("sh_done_busy", ex_busy, 0);

    // SB at 0x3001: lane 1 strobe, byte replicated.
    applyStimulus(MEM_STORE, MEM_B, 1'b0, 12'd1, 6'd0, 1'b0, 32'h0000_3000, 32'h0000_005A);
    checkOutput("sb_wstrb", dc_req_wstrb, 4'b0010);
    checkOutput("sb_wdata", dc_req_wdata, 32'h5A5A_5A5A);
    checkOutput("sb_addr", dc_req_addr, 32'h0000_3000);
    step();
    checkOutput("sb_wb_valid", wb_valid, 1);
    step();

    // Misaligned LW at 0x1001: straight to an excepting writeback.
    applyStimulus(MEM_LOAD, MEM_W, 1'b0, 12'd1, 6'd4, 1'b1, 32'h0000_1000, 32'h0);
    checkOutput("mis_no_req", dc_req_valid, 0);
    checkOutput("mis_wb_valid", wb_valid, 1);
    checkOutput("mis_wb_exc", wb_exception, 1);
    checkOutput("mis_ctb_valid", ctb_valid, 0);
    step();
    checkOutput("mis_done_busy", ex_busy, 0);

    // Misaligned SH at 0x1003 also raises an exception without a request.
    applyStimulus(MEM_STORE, MEM_H, 1'b0, 12'd3, 6'd0, 1'b0, 32'h0000_1000, 32'h0);
    checkOutput("mis_sh_no_req", dc_req_valid, 0);
    checkOutput("mis_sh_exc", wb_exception, 1);
    step();

    // Reset while waiting for a load response; the late response must vanish.
    applyStimulus(MEM_LOAD, MEM_W, 1'b0, 12'd0, 6'd6, 1'b1, 32'h0000_4000, 32'h0);
    step();
    checkOutput("rw_wait_busy", ex_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rw_idle_busy", ex_busy, 0);
    checkOutput("rw_no_req", dc_req_valid, 0);
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("rw_late_no_wb", wb_valid, 0);
      checkOutput("rw_late_busy", ex_busy, 0);
    end
    dc_resp_valid = 1'b0;

    // LW to rd=0, with an illegal second uop offered while busy.
    applyStimulus(MEM_LOAD, MEM_W, 1'b0, 12'd8, 6'd0, 1'b1, 32'h0000_5000, 32'h0);
    checkOutput("r0_req_addr", dc_req_addr, 32'h0000_5008);
    uop.mem_type = MEM_STORE;
    rs1_data     = 32'h0000_6000;
    uop_valid    = 1'b1;
    step();
    uop_valid = 1'b0;
    checkOutput("r0_busy_no_req", dc_req_valid, 0);
    checkOutput("r0_busy_wait", ex_busy, 1);
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'h1122_3344;
    step();
    dc_resp_valid = 1'b0;
    checkOutput("r0_wb_valid", wb_valid, 1);
    checkOutput("r0_wb_data", wb_data, 32'h1122_3344);
    checkOutput("r0_ctb_valid", ctb_valid, 0);
    step();
    checkOutput("r0_idle_no_req", dc_req_valid, 0);
    checkOutput("r0_idle_busy", ex_busy, 0);
    step();
    checkOutput("r0_no_second_req", dc_req_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
